// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned RegAddrWDefault  = 3;
  localparam int unsigned MemTimeoutDefault = 15;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StHalt    = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in ID/EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrWDefault
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_reg_wb_i,
  input  logic [REG_ADDR_W-1:0] ex_wb_addr_i,
  output logic                  load_use_o
);

  logic rs1_hit, rs2_hit;

  // Every register is compared, including register 0.
  assign rs1_hit    = id_uses_rs1_i && (id_rs1_addr_i == ex_wb_addr_i);
  assign rs2_hit    = id_uses_rs2_i && (id_rs2_addr_i == ex_wb_addr_i);
  assign load_use_o = ex_is_load_i && ex_reg_wb_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait, branch flush, load-use bubble, timeout halt.
// Optional stall cycle counter enabled by defining STALL_COUNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned REG_ADDR_W  = RegAddrWDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_wb,
  input  logic [REG_ADDR_W-1:0] ex_wb_addr,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  exe_mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  mem_req,
  output logic                  halted,
  output logic [15:0]           stall_count
);

  localparam logic [7:0] TmoLimit = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic       load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_is_load_i  (ex_is_load),
    .ex_reg_wb_i   (ex_reg_wb),
    .ex_wb_addr_i  (ex_wb_addr),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    exe_mem_wb_en = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_req       = 1'b0;

    case (state_q)
      StRun: begin
        mem_req = ex_is_load;
        if (ex_is_load && !mem_ready) begin
          {pc_en, if_id_en, id_ex_en, exe_mem_wb_en} = 4'b0000;
          tmo_d   = 8'd0;
          state_d = StMemWait;
        end else if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = StFlush;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      StMemWait: begin
        mem_req = 1'b1;
        if (!mem_ready) begin
          {pc_en, if_id_en, id_ex_en, exe_mem_wb_en} = 4'b0000;
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TmoLimit) state_d = StHalt;
        end else begin
          // Data arrives: resolve this cycle with the run rules, then resume.
          tmo_d   = 8'd0;
          state_d = StRun;
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      end
      StFlush: begin
        if_id_flush = 1'b1;
        state_d     = StRun;
      end
      default: begin
        {pc_en, if_id_en, id_ex_en, exe_mem_wb_en} = 4'b0000;
      end
    endcase

    if (reset) begin
      {pc_en, if_id_en, id_ex_en, exe_mem_wb_en} = 4'b0000;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      mem_req      = 1'b0;
      tmo_d        = 8'd0;
      state_d      = StRun;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    tmo_q   <= tmo_d;
  end

  assign halted = (state_q == StHalt);

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 16'h0000;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_rs1_addr, id_rs2_addr, ex_wb_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_reg_wb, mem_ready, branch_taken;
  logic        pc_en, if_id_en, id_ex_en, exe_mem_wb_en, if_id_flush, id_ex_bubble;
  logic        mem_req, halted;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Reference model: pipeline situation described by plain flags and counters.
  bit m_waiting, m_halt, m_flush_next;
  int m_wait_cycles, m_stalls;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TMO),
    .REG_ADDR_W  (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_is_load    (ex_is_load),
    .ex_reg_wb     (ex_reg_wb),
    .ex_wb_addr    (ex_wb_addr),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .exe_mem_wb_en (exe_mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .mem_req       (mem_req),
    .halted        (halted),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rst, input bit ld, input bit wb, input int wd, input int rs1,
                      input int rs2, input bit u1, input bit u2, input bit rdy, input bit br);
    bit lu;
    bit e_pc, e_ifid, e_idex, e_emw, e_flush, e_bub, e_req, e_halt;
    int e_cnt;
    @(negedge clk);
    reset = rst; ex_is_load = ld; ex_reg_wb = wb; ex_wb_addr = 3'(wd);
    id_rs1_addr = 3'(rs1); id_rs2_addr = 3'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
    mem_ready = rdy; branch_taken = br;
    #1;
    lu = ld && wb && ((u1 && rs1 == wd) || (u2 && rs2 == wd));
    {e_pc, e_ifid, e_idex, e_emw} = 4'b1111;
    {e_flush, e_bub, e_req} = 3'b000;
    e_halt = m_halt;
    e_cnt  = m_stalls;
    if (rst) begin
      {e_pc, e_ifid, e_idex, e_emw} = 4'b0000;
      m_waiting = 0; m_halt = 0; m_flush_next = 0; m_wait_cycles = 0; m_stalls = 0;
    end else if (m_halt) begin
      {e_pc, e_ifid, e_idex, e_emw} = 4'b0000;
    end else if (m_flush_next) begin
      e_flush = 1; m_flush_next = 0;
    end else if (m_waiting && !rdy) begin
      e_req = 1;
      {e_pc, e_ifid, e_idex, e_emw} = 4'b0000;
      m_wait_cycles++;
      if (m_wait_cycles >= TMO) begin m_halt = 1; m_waiting = 0; end
    end else if (!m_waiting && ld && !rdy) begin
      e_req = 1;
      {e_pc, e_ifid, e_idex, e_emw} = 4'b0000;
      m_waiting = 1; m_wait_cycles = 0;
    end else begin
      // Normal issue; a wait that just completed resumes running, never into the flush slot.
      e_req = m_waiting ? 1'b1 : ld;
      if (br) begin
        e_flush = 1; e_bub = 1;
        if (!m_waiting) m_flush_next = 1;
      end else if (lu) begin
        e_pc = 0; e_ifid = 0; e_bub = 1;
      end
      m_waiting = 0; m_wait_cycles = 0;
    end
`ifdef STALL_COUNT_EN
    if (!rst && !e_pc && m_stalls < 65535) m_stalls++;
`else
    e_cnt = 0; m_stalls = 0;
`endif
    chk("pc_en", 16'(pc_en), 16'(e_pc));
    chk("if_id_en", 16'(if_id_en), 16'(e_ifid));
    chk("id_ex_en", 16'(id_ex_en), 16'(e_idex));
    chk("exe_mem_wb_en", 16'(exe_mem_wb_en), 16'(e_emw));
    chk("if_id_flush", 16'(if_id_flush), 16'(e_flush));
    chk("id_ex_bubble", 16'(id_ex_bubble), 16'(e_bub));
    chk("mem_req", 16'(mem_req), 16'(e_req));
    chk("halted", 16'(halted), 16'(e_halt));
    chk("stall_count", stall_count, 16'(e_cnt));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
  endtask

  initial begin
    int frozen;
    bit hit;
    reset = 1; ex_is_load = 0; ex_reg_wb = 0; ex_wb_addr = 0; id_rs1_addr = 0;
    id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; mem_ready = 1; branch_taken = 0;
    m_waiting = 0; m_halt = 0; m_flush_next = 0; m_wait_cycles = 0; m_stalls = 0;
    repeat (2) @(posedge clk);

    // Reset state, then normal flow.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();

    // Load-use on rs2 with data ready: single bubble.
    step(0, 1, 1, 3, 5, 3, 1, 1, 1, 0);
    idle();

    // Load waits four cycles, then completes.
    repeat (4) step(0, 1, 1, 3, 1, 2, 0, 0, 0, 0);
    step(0, 1, 1, 3, 1, 2, 0, 0, 1, 0);
    idle();

    // Branch with concurrent load-use: flush wins, then flush slot.
    step(0, 1, 1, 4, 4, 0, 1, 0, 1, 1);
    step(0, 1, 1, 4, 4, 0, 1, 0, 1, 1);
    idle();

    // Memory freeze beats branch.
    step(0, 1, 1, 2, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    idle();

    // Reset in the middle of a memory wait.
    step(0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    idle();

    // Timeout: count frozen cycles until halted, bounded.
    frozen = 0; hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 1, 1, 1, 2, 4, 0, 0, 0, 0);
      if (halted === 1'b1) hit = 1;
      else if (pc_en === 1'b0) frozen++;
    end
    chk("halt_reached", 16'(hit), 16'd1);
    chk("frozen_cycles", 16'(frozen), 16'd16);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
           $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
